// File: rtl/arb_pkg.sv
// Shared types for the data-memory arbiter.
package arb_pkg;

    // Which side currently has priority on a conflict.
    typedef enum logic {
        OWN_CORE,
        OWN_EXT
    } arb_state_t;

    // Which requester drives the memory this cycle.
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_CORE,
        SEL_EXT
    } arb_sel_t;

    localparam int unsigned STREAK_W = 3;

endpackage

// File: rtl/arb_fairness.sv
// Ownership state, streak counter and per-cycle requester selection.
module arb_fairness
    import arb_pkg::*;
#(
    parameter int unsigned CORE_MAX = 4,
    parameter int unsigned EXT_MAX  = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     core_req,
    input  logic     ext_req,
    output arb_sel_t sel
);

    localparam logic [STREAK_W-1:0] CORE_LIM = STREAK_W'(CORE_MAX);
    localparam logic [STREAK_W-1:0] EXT_LIM  = STREAK_W'(EXT_MAX);

    arb_state_t          state, state_nx;
    logic [STREAK_W-1:0] streak, streak_nx;

    // State and streak registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= OWN_CORE;
            streak <= '0;
        end else begin
            state  <= state_nx;
            streak <= streak_nx;
        end
    end

    // Owner keeps a conflict until its streak reaches its limit; the winner
    // of a handover starts its new streak at 1.
    always_comb begin
        state_nx  = state;
        streak_nx = streak;
        sel       = SEL_NONE;
        case (state)
            OWN_CORE: begin
                if (core_req && ext_req) begin
                    if (streak < CORE_LIM) begin
                        sel       = SEL_CORE;
                        streak_nx = streak + 1'b1;
                    end else begin
                        sel       = SEL_EXT;
                        state_nx  = OWN_EXT;
                        streak_nx = STREAK_W'(1);
                    end
                end else if (core_req) begin
                    sel = SEL_CORE;
                end else if (ext_req) begin
                    sel       = SEL_EXT;
                    state_nx  = OWN_EXT;
                    streak_nx = STREAK_W'(1);
                end else begin
                    streak_nx = '0;
                end
            end
            OWN_EXT: begin
                if (core_req && ext_req) begin
                    if (streak < EXT_LIM) begin
                        sel       = SEL_EXT;
                        streak_nx = streak + 1'b1;
                    end else begin
                        sel       = SEL_CORE;
                        state_nx  = OWN_CORE;
                        streak_nx = STREAK_W'(1);
                    end
                end else if (ext_req) begin
                    sel = SEL_EXT;
                end else if (core_req) begin
                    sel       = SEL_CORE;
                    state_nx  = OWN_CORE;
                    streak_nx = STREAK_W'(1);
                end else begin
                    streak_nx = '0;
                end
            end
            default: begin
                state_nx  = OWN_CORE;
                streak_nx = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core and an external port.
module dmem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned CORE_MAX = 4,
    parameter int unsigned EXT_MAX  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       core_rd,
    input  logic       core_wr,
    input  logic [7:0] core_addr,
    input  logic [7:0] core_wdata,
    output logic [7:0] core_rdata,
    output logic       core_stall,
    input  logic       ext_req,
    input  logic       ext_we,
    input  logic [7:0] ext_addr,
    input  logic [7:0] ext_wdata,
    output logic       ext_gnt,
    output logic       ext_rvalid,
    output logic [7:0] ext_rdata,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    arb_sel_t sel;
    logic     core_req;

    assign core_req = core_rd | core_wr;

    arb_fairness #(
        .CORE_MAX (CORE_MAX),
        .EXT_MAX  (EXT_MAX)
    ) u_fair (
        .clk      (clk),
        .rst      (rst),
        .core_req (core_req),
        .ext_req  (ext_req),
        .sel      (sel)
    );

    assign ext_gnt    = (sel == SEL_EXT);
    assign core_stall = core_req & ext_gnt;

    // Route the served requester onto the memory bus; rd+wr from the core is a write.
    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        core_rdata = '0;
        case (sel)
            SEL_CORE: begin
                mem_wr     = core_wr;
                mem_rd     = core_rd & ~core_wr;
                mem_addr   = core_addr;
                mem_wdata  = core_wdata;
                core_rdata = mem_rdata;
            end
            SEL_EXT: begin
                mem_wr    = ext_we;
                mem_rd    = ~ext_we;
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
            end
            default: ;
        endcase
    end

    // Capture external read data on the grant edge; valid pulses the next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_rvalid <= 1'b0;
            ext_rdata  <= '0;
        end else begin
            ext_rvalid <= ext_gnt & ~ext_we;
            if (ext_gnt && !ext_we) begin
                ext_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;
    import arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       core_rd, core_wr;
    logic [7:0] core_addr, core_wdata, core_rdata;
    logic       core_stall;
    logic       ext_req, ext_we;
    logic [7:0] ext_addr, ext_wdata;
    logic       ext_gnt, ext_rvalid;
    logic [7:0] ext_rdata;
    logic       mem_rd, mem_wr;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [256];

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.CORE_MAX(4), .EXT_MAX(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_rd    (core_rd),
        .core_wr    (core_wr),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // DataMemory model: combinational read, synchronous write.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic crd, input logic cwr, input logic [7:0] ca, input logic [7:0] cd,
                         input logic ereq, input logic ewe, input logic [7:0] ea, input logic [7:0] ed);
        @(negedge clk);
        core_rd = crd; core_wr = cwr; core_addr = ca; core_wdata = cd;
        ext_req = ereq; ext_we = ewe; ext_addr = ea; ext_wdata = ed;
        #1;
    endtask

    function automatic logic [31:0] st();
        return 32'(dut.u_fair.state);
    endfunction

    function automatic logic [31:0] sk();
        return 32'(dut.u_fair.streak);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        rst = 1'b0;
        core_rd = 0; core_wr = 0; core_addr = 0; core_wdata = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
        #2;
        chk("rst_rvalid", 32'(ext_rvalid), 0);
        chk("rst_rdata",  32'(ext_rdata), 0);
        chk("rst_state",  st(), 32'(OWN_CORE));
        chk("rst_streak", sk(), 0);
        chk("rst_gnt",    32'(ext_gnt), 0);
        chk("rst_memwr",  32'(mem_wr), 0);
        @(negedge clk); rst = 1'b1;

        // core only
        drive(0, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
        chk("cw_memwr",  32'(mem_wr), 1);
        chk("cw_addr",   32'(mem_addr), 32'h10);
        chk("cw_wdata",  32'(mem_wdata), 32'hA5);
        chk("cw_stall",  32'(core_stall), 0);
        chk("cw_gnt",    32'(ext_gnt), 0);
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("cr_memrd",  32'(mem_rd), 1);
        chk("cr_rdata",  32'(core_rdata), 32'hA5);
        chk("cr_stall",  32'(core_stall), 0);
        drive(1, 1, 8'h11, 8'h5A, 0, 0, 8'h00, 8'h00);
        chk("crw_memwr", 32'(mem_wr), 1);
        chk("crw_memrd", 32'(mem_rd), 0);
        drive(1, 0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("crw_rback", 32'(core_rdata), 32'h5A);

        // ext only
        drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C);
        chk("ew_gnt",    32'(ext_gnt), 1);
        chk("ew_memwr",  32'(mem_wr), 1);
        chk("ew_addr",   32'(mem_addr), 32'h20);
        chk("ew_wdata",  32'(mem_wdata), 32'h3C);
        chk("ew_stall",  32'(core_stall), 0);
        chk("ew_crdata", 32'(core_rdata), 0);
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00);
        chk("er_gnt",    32'(ext_gnt), 1);
        chk("er_memrd",  32'(mem_rd), 1);
        chk("er_novalid", 32'(ext_rvalid), 0);
        chk("er_state",  st(), 32'(OWN_EXT));
        chk("er_streak", sk(), 1);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("er_rvalid", 32'(ext_rvalid), 1);
        chk("er_rdata",  32'(ext_rdata), 32'h3C);
        chk("idle_state", st(), 32'(OWN_EXT));
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("er_pulse",  32'(ext_rvalid), 0);
        chk("er_hold",   32'(ext_rdata), 32'h3C);
        chk("idle_streak", sk(), 0);
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("back_core", 32'(core_rdata), 32'hA5);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("back_state", st(), 32'(OWN_CORE));
        chk("back_streak", sk(), 1);

        // contention
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
            chk("cont_streak", sk(), 32'(i));
            chk("cont_gnt",    32'(ext_gnt), 0);
            chk("cont_stall",  32'(core_stall), 0);
            chk("cont_rdata",  32'(core_rdata), 32'hA5);
        end
        drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
        chk("c4_gnt",    32'(ext_gnt), 1);
        chk("c4_stall",  32'(core_stall), 1);
        chk("c4_crdata", 32'(core_rdata), 0);
        chk("c4_addr",   32'(mem_addr), 32'h20);
        chk("c4_streak", sk(), 4);
        drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
        chk("c5_gnt",    32'(ext_gnt), 1);
        chk("c5_stall",  32'(core_stall), 1);
        chk("c5_rvalid", 32'(ext_rvalid), 1);
        chk("c5_rdata",  32'(ext_rdata), 32'h3C);
        drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
        chk("c6_gnt",    32'(ext_gnt), 0);
        chk("c6_stall",  32'(core_stall), 0);
        chk("c6_crdata", 32'(core_rdata), 32'hA5);
        chk("c6_streak", sk(), 2);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("c7_state",  st(), 32'(OWN_CORE));
        chk("c7_streak", sk(), 1);

        // idle cycle clears the streak
        for (int i = 0; i < 3; i++) drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("idle_pre",  sk(), 3);
        drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
        chk("idle_clr",  sk(), 0);
        chk("idle_gnt",  32'(ext_gnt), 0);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("idle_restart", sk(), 1);

        // async reset with an external read in flight
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00);
        chk("ar_gnt", 32'(ext_gnt), 1);
        @(posedge clk); #2;
        chk("ar_pre_valid", 32'(ext_rvalid), 1);
        chk("ar_pre_state", st(), 32'(OWN_EXT));
        rst = 1'b0;
        #1;
        chk("ar_valid",  32'(ext_rvalid), 0);
        chk("ar_state",  st(), 32'(OWN_CORE));
        chk("ar_rdata",  32'(ext_rdata), 0);
        chk("ar_streak", sk(), 0);
        @(negedge clk);
        rst = 1'b1; ext_req = 0;
        drive(0, 1, 8'h30, 8'h77, 0, 0, 8'h00, 8'h00);
        chk("ar_cw_wr",    32'(mem_wr), 1);
        chk("ar_cw_stall", 32'(core_stall), 0);
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00);
        chk("raw_gnt",  32'(ext_gnt), 1);
        chk("raw_addr", 32'(mem_addr), 32'h30);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("raw_valid", 32'(ext_rvalid), 1);
        chk("raw_rdata", 32'(ext_rdata), 32'h77);

        // external request abandoned before grant
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("ab_gnt0", 32'(ext_gnt), 0);
        drive(0, 1, 8'h40, 8'h11, 1, 1, 8'h41, 8'hEE);
        chk("ab_gnt1",  32'(ext_gnt), 0);
        chk("ab_stall1", 32'(core_stall), 0);
        chk("ab_addr1", 32'(mem_addr), 32'h40);
        drive(0, 1, 8'h40, 8'h11, 0, 0, 8'h00, 8'h00);
        chk("ab_gnt2",  32'(ext_gnt), 0);
        chk("ab_stall2", 32'(core_stall), 0);
        drive(1, 0, 8'h41, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("ab_untouched", 32'(core_rdata), 32'h1B);
        drive(1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("ab_core_wr", 32'(core_rdata), 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
